// File: rtl/oc_ram_stream_writer.sv
// Stream-to-RAM writer: buffers a valid/ready word stream in a small FIFO and writes it as an
// Avalon-MM master into a wrapping window of the on-chip RAM. Define OC_RAM_WRITER_VERIFY_EN for read-back checking.
module oc_ram_stream_writer #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int RAM_DEPTH  = 5120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  input  logic [DATA_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [ADDR_W-1:0]   ram_address,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata,
  output logic                busy,
  output logic                done,
  output logic                error,
`ifdef OC_RAM_WRITER_VERIFY_EN
  output logic [ADDR_W-1:0]   mismatch_addr,
`endif
  output logic [ADDR_W-1:0]   word_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(RAM_DEPTH);
  localparam logic [PTR_W:0]    PTR_INC = (PTR_W+1)'(1);
  localparam logic [ADDR_W-1:0] CNT_INC = ADDR_W'(1);

  logic [1:0]        state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] accepted_q;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr_q;
  logic [PTR_W:0]    rd_ptr_q;
  logic              fifo_empty;
  logic              fifo_full;

  logic              bad_params;
  logic              push;
  logic              pop;
  logic              wr_slot;
  logic              finishing;
  logic [ADDR_W:0]   addr_sum;
  logic [ADDR_W-1:0] next_addr;

`ifdef OC_RAM_WRITER_VERIFY_EN
  logic              cmp_pend_q;
  logic [ADDR_W-1:0] cmp_addr_q;
  logic [DATA_W-1:0] cmp_data_q;
  logic              mm_seen_q;
`else
  logic              unused_readdata;
  assign unused_readdata = ^ram_readdata;
`endif

  assign ram_byteenable = '1;
  assign ram_clken      = 1'b1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign s_ready = (state_q == S_RUN) && !fifo_full && (accepted_q < len_q);

  assign bad_params = (length == '0) || ({1'b0, base_addr} >= DEPTH_X);
  assign push       = s_valid && s_ready && !abort;

`ifdef OC_RAM_WRITER_VERIFY_EN
  // A write cycle is always followed by its read-back cycle, so no pop then.
  assign wr_slot   = !ram_write;
  assign finishing = (word_count == len_q) && cmp_pend_q && !ram_chipselect;
`else
  assign wr_slot   = 1'b1;
  assign finishing = (word_count == len_q) && ram_write;
`endif

  assign pop = (state_q == S_RUN) && !abort && !fifo_empty && wr_slot;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    addr_sum  = {1'b0, base_q} + {1'b0, word_count};
    next_addr = addr_sum[ADDR_W-1:0];
    if (addr_sum >= DEPTH_X) begin
      next_addr = ADDR_W'(addr_sum - DEPTH_X);
    end
  end

  // NOTE: storage arrays carry no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= s_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      len_q          <= '0;
      accepted_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_writedata  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      word_count     <= '0;
`ifdef OC_RAM_WRITER_VERIFY_EN
      cmp_pend_q     <= 1'b0;
      cmp_addr_q     <= '0;
      cmp_data_q     <= '0;
      mm_seen_q      <= 1'b0;
      mismatch_addr  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          ram_chipselect <= 1'b0;
          ram_write      <= 1'b0;
          // Abort outranks start; a simultaneous pair is dropped with error untouched.
          if (start && !abort) begin
            base_q     <= base_addr;
            len_q      <= length;
            accepted_q <= '0;
            word_count <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
`ifdef OC_RAM_WRITER_VERIFY_EN
            cmp_pend_q <= 1'b0;
            mm_seen_q  <= 1'b0;
`endif
            if (bad_params) begin
              state_q <= S_DONE;
              done    <= 1'b1;
              error   <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy    <= 1'b1;
              error   <= 1'b0;
            end
          end
        end

        S_RUN: begin
          if (abort) begin
            state_q        <= S_IDLE;
            busy           <= 1'b0;
            error          <= 1'b1;
            ram_chipselect <= 1'b0;
            ram_write      <= 1'b0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
`ifdef OC_RAM_WRITER_VERIFY_EN
            cmp_pend_q     <= 1'b0;
`endif
          end else begin
            if (push) begin
              wr_ptr_q   <= wr_ptr_q + PTR_INC;
              accepted_q <= accepted_q + CNT_INC;
            end
            if (pop) begin
              rd_ptr_q      <= rd_ptr_q + PTR_INC;
              word_count    <= word_count + CNT_INC;
              ram_address   <= next_addr;
              ram_writedata <= fifo_mem[rd_ptr_q[PTR_W-1:0]];
            end
`ifdef OC_RAM_WRITER_VERIFY_EN
            // Address and write data are held through the read-back cycle.
            ram_chipselect <= pop || ram_write;
            ram_write      <= pop;
            cmp_pend_q     <= ram_chipselect && !ram_write;
            if (ram_chipselect && !ram_write) begin
              cmp_addr_q <= ram_address;
              cmp_data_q <= ram_writedata;
            end
            if (cmp_pend_q && (ram_readdata != cmp_data_q)) begin
              error <= 1'b1;
              if (!mm_seen_q) begin
                mm_seen_q     <= 1'b1;
                mismatch_addr <= cmp_addr_q;
              end
            end
`else
            ram_chipselect <= pop;
            ram_write      <= pop;
`endif
            if (finishing) begin
              state_q <= S_DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
            end
          end
        end

        S_DONE: begin
          ram_chipselect <= 1'b0;
          ram_write      <= 1'b0;
          state_q        <= S_IDLE;
          if (abort) begin
            error <= 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oc_ram_stream_writer.sv
// Directed bench for oc_ram_stream_writer: expected RAM writes go into a scoreboard queue that a
// negedge monitor drains; status outputs are compared directly by the stimulus thread.
`timescale 1ns/1ps
module tb_oc_ram_stream_writer;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int RAM_DEPTH = 5120;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] length;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_chipselect;
  logic              ram_write;
  logic [DATA_W-1:0] ram_writedata;
  logic [3:0]        ram_byteenable;
  logic              ram_clken;
  logic [DATA_W-1:0] ram_readdata = '0;
  logic              busy;
  logic              done;
  logic              error;
  logic [ADDR_W-1:0] word_count;
`ifdef OC_RAM_WRITER_VERIFY_EN
  logic [ADDR_W-1:0] mismatch_addr;
`endif

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               exp_q[$];
  logic [DATA_W-1:0] src_q[$];
  wr_t               mon_e;
  int                vectors    = 0;
  int                miscompares = 0;
  int                cyc        = 0;
  int                hs_count   = 0;

  int   n_wr, n_rd, first_c, last_c, done_c;
  logic busy_d, rdy_l;

  oc_ram_stream_writer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .abort          (abort),
    .base_addr      (base_addr),
    .length         (length),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .ram_address    (ram_address),
    .ram_chipselect (ram_chipselect),
    .ram_write      (ram_write),
    .ram_writedata  (ram_writedata),
    .ram_byteenable (ram_byteenable),
    .ram_clken      (ram_clken),
    .ram_readdata   (ram_readdata),
    .busy           (busy),
    .done           (done),
    .error          (error),
`ifdef OC_RAM_WRITER_VERIFY_EN
    .mismatch_addr  (mismatch_addr),
`endif
    .word_count     (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // RAM model; word 7 reads back corrupted to exercise the verify path.
  logic [DATA_W-1:0] ram_mem [0:RAM_DEPTH-1];
  always @(posedge clk) begin
    if (ram_chipselect && ram_write) ram_mem[ram_address] <= ram_writedata;
    if (ram_chipselect && !ram_write)
      ram_readdata <= (ram_address == 13'd7) ? (ram_mem[ram_address] ^ 32'h0000_00FF) : ram_mem[ram_address];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp_v);
    end
  endtask

  // Scoreboard monitor: every RAM write strobe must match the head of exp_q.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && ram_chipselect && ram_write) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got addr %0d data 0x%0h, required no write", ram_address, ram_writedata);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 64'(ram_address), 64'(mon_e.addr));
          check("wr_data", 64'(ram_writedata), 64'(mon_e.data));
        end
      end
    end
  end

  // Stream source: offers src_q head; handshake judged mid-cycle, inputs change just after posedge.
  initial begin
    s_valid = 1'b0;
    s_data  = '0;
    forever begin
      @(negedge clk);
      if (s_valid && s_ready && src_q.size() > 0) begin
        void'(src_q.pop_front());
        hs_count++;
      end
      @(posedge clk);
      #1;
      s_valid = (src_q.size() > 0);
      s_data  = (src_q.size() > 0) ? src_q[0] : '0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
    @(negedge clk);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic load(input logic [DATA_W-1:0] first, input int n, input logic [ADDR_W-1:0] b, input int n_exp);
    for (int i = 0; i < n; i++) src_q.push_back(first + DATA_W'(i));
    for (int i = 0; i < n_exp; i++) begin
      wr_t e;
      e.addr = ADDR_W'((int'(b) + i) % RAM_DEPTH);
      e.data = first + DATA_W'(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_until_done(input string tag, input int bound, output int nw, output int nr,
                                output int fc, output int lc, output int dc, output logic bz, output logic rdy);
    nw = 0; nr = 0; fc = -1; lc = -1; dc = -1; bz = 1'b1; rdy = 1'b1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (ram_chipselect && ram_write) begin
        if (nw == 0) fc = cyc;
        lc  = cyc;
        rdy = s_ready;
        nw++;
      end
      if (ram_chipselect && !ram_write) nr++;
      if (done) begin
        dc = cyc;
        bz = busy;
        break;
      end
    end
    check({tag, "_done_seen"}, 64'(dc >= 0), 64'(1));
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_chipselect", 64'(ram_chipselect), 64'(0));
    check("rst_write", 64'(ram_write), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_error", 64'(error), 64'(0));
    check("rst_address", 64'(ram_address), 64'(0));
    check("rst_writedata", 64'(ram_writedata), 64'(0));
    check("rst_word_count", 64'(word_count), 64'(0));
    check("byteenable", 64'(ram_byteenable), 64'(4'hF));
    check("clken", 64'(ram_clken), 64'(1));

    // 1: base 0, len 4, back-to-back stream
    load(32'hA0, 4, 13'd0, 4);
    do_start(13'd0, 13'd4);
    check("t1_busy", 64'(busy), 64'(1));
    run_until_done("t1", 60, n_wr, n_rd, first_c, last_c, done_c, busy_d, rdy_l);
    check("t1_writes", 64'(n_wr), 64'(4));
`ifndef OC_RAM_WRITER_VERIFY_EN
    check("t1_consecutive", 64'(last_c - first_c), 64'(3));
    check("t1_done_latency", 64'(done_c - last_c), 64'(1));
`endif
    check("t1_busy_at_done", 64'(busy_d), 64'(0));
    check("t1_word_count", 64'(word_count), 64'(4));
    check("t1_error", 64'(error), 64'(0));
    @(negedge clk);
    check("t1_done_one_cycle", 64'(done), 64'(0));

    // 3: len 3 while the source offers 5 beats
    hs_count = 0;
    load(32'hD0, 5, 13'd20, 3);
    do_start(13'd20, 13'd3);
    run_until_done("t3", 60, n_wr, n_rd, first_c, last_c, done_c, busy_d, rdy_l);
    check("t3_handshakes", 64'(hs_count), 64'(3));
    check("t3_ready_after_len", 64'(rdy_l), 64'(0));
    check("t3_pending_beats", 64'(src_q.size()), 64'(2));
    check("t3_word_count", 64'(word_count), 64'(3));
    @(negedge clk);
    src_q.delete();

    // 4: zero length -> immediate done with error, no writes
    do_start(13'd0, 13'd0);
    run_until_done("t4", 20, n_wr, n_rd, first_c, last_c, done_c, busy_d, rdy_l);
    check("t4_writes", 64'(n_wr), 64'(0));
    check("t4_error", 64'(error), 64'(1));
    check("t4_busy", 64'(busy_d), 64'(0));

    // out-of-range base behaves like a rejected start
    do_start(13'd5120, 13'd1);
    run_until_done("tb_base", 20, n_wr, n_rd, first_c, last_c, done_c, busy_d, rdy_l);
    check("tbase_writes", 64'(n_wr), 64'(0));
    check("tbase_error", 64'(error), 64'(1));

    // 2: window wrapping at RAM_DEPTH; the valid start also clears error
    load(32'hB0, 4, 13'd5118, 4);
    do_start(13'd5118, 13'd4);
    check("t2_error_cleared", 64'(error), 64'(0));
    run_until_done("t2", 60, n_wr, n_rd, first_c, last_c, done_c, busy_d, rdy_l);
    check("t2_writes", 64'(n_wr), 64'(4));
    check("t2_error", 64'(error), 64'(0));
    @(negedge clk);

    // simultaneous start+abort in IDLE: start dropped, error kept
    @(negedge clk);
    base_addr = 13'd50; length = 13'd2; start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("sa_busy", 64'(busy), 64'(0));
    check("sa_error", 64'(error), 64'(0));

    // 5: abort after 2 of 8 writes
    load(32'hF0, 8, 13'd40, 2);
    do_start(13'd40, 13'd8);
    n_wr = 0;
    for (int i = 0; i < 40 && n_wr < 2; i++) begin
      @(negedge clk);
      if (ram_chipselect && ram_write) n_wr++;
    end
    check("t5_two_writes", 64'(n_wr), 64'(2));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_chipselect", 64'(ram_chipselect), 64'(0));
    check("t5_write", 64'(ram_write), 64'(0));
    check("t5_busy", 64'(busy), 64'(0));
    check("t5_error", 64'(error), 64'(1));
    src_q.delete();
    n_wr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) n_wr++;
    end
    check("t5_no_done", 64'(n_wr), 64'(0));

    // follow-on transfer: stale FIFO contents would show up as wrong write data
    load(32'hC0, 2, 13'd100, 2);
    do_start(13'd100, 13'd2);
    run_until_done("t5b", 60, n_wr, n_rd, first_c, last_c, done_c, busy_d, rdy_l);
    check("t5b_writes", 64'(n_wr), 64'(2));
    check("t5b_error", 64'(error), 64'(0));
    check("t5b_word_count", 64'(word_count), 64'(2));
    @(negedge clk);

`ifdef OC_RAM_WRITER_VERIFY_EN
    // 6: read-back mismatch at word 7
    load(32'hE0, 3, 13'd6, 3);
    do_start(13'd6, 13'd3);
    run_until_done("t6", 60, n_wr, n_rd, first_c, last_c, done_c, busy_d, rdy_l);
    check("t6_writes", 64'(n_wr), 64'(3));
    check("t6_reads", 64'(n_rd), 64'(3));
    check("t6_alternation", 64'(last_c - first_c), 64'(4));
    check("t6_done_latency", 64'(done_c - last_c), 64'(3));
    check("t6_error", 64'(error), 64'(1));
    check("t6_mismatch_addr", 64'(mismatch_addr), 64'(7));
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
